// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory responder: responder states, bus
// direction codes and the default address/data widths of the CPU bus.
package cpu_bus_pkg;

    localparam int unsigned CPU_AW = 12;
    localparam int unsigned CPU_DW = 16;

    // Bus direction as driven on cpu_rdwr
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Responder states: CPU held in reset, loading, CPU running
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_mem_array.sv
// Single-port synchronous word array with one write port and one registered
// read port. The read register is reset and can load zero instead of memory
// data so the owner can answer unmapped reads.
// Ports:
//   clk, rstT  - clock, async active-high reset (read register only)
//   we         - write mem[addr] <= wdata
//   re         - load read register
//   rd_zero    - with re, load zero instead of mem[addr]
//   addr       - word index
//   wdata      - write data
//   rdata      - registered read data, held between reads
module cpu_mem_array #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          rstT,
    input  logic          we,
    input  logic          re,
    input  logic          rd_zero,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage is intentionally not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rstT) begin
        if (rstT) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_zero ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit accumulator CPU. A boot loader fills
// memory from a valid/ready stream while the CPU is held in reset, then the
// CPU is released and its reads/writes are serviced with one-clock latency.
// Ports:
//   clk, rstT              - clock, async active-high reset
//   cpu_addr/en/rdwr/wdata - CPU bus request (rdwr 1 = write)
//   cpu_rdata              - registered read data to the CPU
//   cpu_rst                - CPU reset, high while not running
//   run_start, ld_start    - release CPU / begin program load
//   ld_valid/data/last     - loader stream, ld_ready is the handshake
//   ld_count               - words written by the current or last load
//   unmapped               - sticky flag for CPU accesses at or above DEPTH
module cpu_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned AW    = CPU_AW,
    parameter int unsigned DW    = CPU_DW,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rstT,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_en,
    input  logic          cpu_rdwr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rst,
    input  logic          run_start,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW-1:0] ld_count,
    output logic          unmapped
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] ld_count_d;
    logic          ld_xfer;
    logic          cpu_act;
    logic          cpu_mapped;
    logic          mem_we, mem_re, mem_rd_zero;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // Extra top bit keeps the compare correct when DEPTH == 2**AW
    assign cpu_mapped = ({1'b0, cpu_addr} < (AW+1)'(DEPTH));
    assign cpu_act    = (state_q == RUN) && cpu_en;

    // Next-state and load counter
    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count;
        ld_xfer    = 1'b0;
        case (state_q)
            HOLD: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                end else if (run_start) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready) begin
                    ld_xfer    = 1'b1;
                    ld_count_d = ld_count + AW'(1);
                    // Filling the last implemented word ends the load
                    if (ld_last || (ld_count == AW'(DEPTH - 1))) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Single memory port shared by loader (LOAD) and CPU (RUN)
    always_comb begin
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_rd_zero = 1'b0;
        mem_addr    = cpu_addr[IW-1:0];
        mem_wdata   = cpu_wdata;
        if (state_q == LOAD) begin
            mem_we    = ld_xfer;
            mem_addr  = ld_count[IW-1:0];
            mem_wdata = ld_data;
        end else if (cpu_act) begin
            if (cpu_rdwr == WR) begin
                mem_we = cpu_mapped;
            end else begin
                mem_re      = 1'b1;
                mem_rd_zero = !cpu_mapped;
            end
        end
    end

    // State and registered control outputs
    always_ff @(posedge clk or posedge rstT) begin
        if (rstT) begin
            state_q  <= HOLD;
            cpu_rst  <= 1'b1;
            ld_ready <= 1'b0;
            ld_count <= '0;
            unmapped <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_rst  <= (state_d != RUN);
            ld_ready <= (state_d == LOAD);
            ld_count <= ld_count_d;
            if (cpu_act && !cpu_mapped) begin
                unmapped <= 1'b1;
            end
        end
    end

    cpu_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .rstT    (rstT),
        .we      (mem_we),
        .re      (mem_re),
        .rd_zero (mem_rd_zero),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (cpu_rdata)
    );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: loader, CPU bus, unmapped flag,
// full load, backpressure and reset-mid-load scenarios. Read results are
// checked through a scoreboard queue fed from a bench-side memory model.
module tb_cpu_mem_responder;

    logic        clk;
    logic        rstT;
    logic [11:0] cpu_addr;
    logic        cpu_en;
    logic        cpu_rdwr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rst;
    logic        run_start;
    logic        ld_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [11:0] ld_count;
    logic        unmapped;

    int          n_assert;
    int          n_fail;
    logic [15:0] mdl [256];
    logic [15:0] exp_q [$];

    cpu_mem_responder #(.AW(12), .DW(16), .DEPTH(256)) dut (
        .clk       (clk),
        .rstT      (rstT),
        .cpu_addr  (cpu_addr),
        .cpu_en    (cpu_en),
        .cpu_rdwr  (cpu_rdwr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rst   (cpu_rst),
        .run_start (run_start),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_count  (ld_count),
        .unmapped  (unmapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rdwr  = 1'b1;
        cpu_en    = 1'b1;
        step();
        cpu_en    = 1'b0;
        if (a < 12'h100) mdl[a[7:0]] = d;
    endtask

    task automatic cpu_read(input string tag, input logic [11:0] a);
        logic [15:0] got;
        exp_q.push_back((a < 12'h100) ? mdl[a[7:0]] : 16'h0000);
        cpu_addr = a;
        cpu_rdwr = 1'b0;
        cpu_en   = 1'b1;
        step();
        cpu_en   = 1'b0;
        got = exp_q.pop_front();
        chk(tag, cpu_rdata, got);
    endtask

    initial begin
        logic [15:0] held;
        n_assert  = 0;
        n_fail    = 0;
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
        rstT      = 1'b1;
        cpu_addr  = '0;
        cpu_en    = 1'b0;
        cpu_rdwr  = 1'b0;
        cpu_wdata = '0;
        run_start = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        step();
        step();
        chk("rst_cpu_rst",   16'(cpu_rst),  16'h1);
        chk("rst_rdata",     cpu_rdata,     16'h0);
        chk("rst_ld_ready",  16'(ld_ready), 16'h0);
        chk("rst_ld_count",  16'(ld_count), 16'h0);
        chk("rst_unmapped",  16'(unmapped), 16'h0);
        rstT = 1'b0;
        step();
        chk("hold_cpu_rst",  16'(cpu_rst),  16'h1);

        // Load and run; ld_start beats a simultaneous run_start
        ld_start  = 1'b1;
        run_start = 1'b1;
        step();
        ld_start  = 1'b0;
        run_start = 1'b0;
        chk("load_ready",    16'(ld_ready), 16'h1);
        chk("load_cpu_rst",  16'(cpu_rst),  16'h1);
        load_word(16'h7800, 1'b0); mdl[0] = 16'h7800;
        load_word(16'h1234, 1'b0); mdl[1] = 16'h1234;
        chk("load2_cpu_rst", 16'(cpu_rst),  16'h1);
        load_word(16'hABCD, 1'b1); mdl[2] = 16'hABCD;
        chk("load3_count",   16'(ld_count), 16'h3);
        chk("load3_cpu_rst", 16'(cpu_rst),  16'h0);
        chk("load3_ready",   16'(ld_ready), 16'h0);
        cpu_read("rd_a1", 12'h001);
        cpu_read("rd_a0", 12'h000);
        cpu_read("rd_a2", 12'h002);

        // Write then read, neighbour unaffected, read data held over writes
        cpu_write(12'h011, 16'h1111);
        cpu_write(12'h010, 16'h5A5A);
        chk("wr_rdata_hold", cpu_rdata, 16'hABCD);
        cpu_read("rd_a10", 12'h010);
        cpu_read("rd_a11", 12'h011);
        step();
        step();
        chk("idle_rdata_hold", cpu_rdata, 16'h1111);

        // Unmapped access; 0x100 must not alias onto word 0
        cpu_write(12'h100, 16'hFFFF);
        chk("unm_set",       16'(unmapped), 16'h1);
        cpu_read("rd_unm", 12'h100);
        cpu_read("rd_a0_alias", 12'h000);
        cpu_read("rd_unm_hi", 12'hFFF);
        cpu_read("rd_a1_again", 12'h001);
        chk("unm_sticky",    16'(unmapped), 16'h1);

        // Reload from RUN with idle cycles and a CPU write pulse during LOAD
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("reld_cpu_rst",  16'(cpu_rst),  16'h1);
        chk("reld_count",    16'(ld_count), 16'h0);
        load_word(16'h0A0A, 1'b0); mdl[0] = 16'h0A0A;
        ld_data = 16'hEEEE;
        step();
        load_word(16'h0B0B, 1'b0); mdl[1] = 16'h0B0B;
        chk("bp_count",      16'(ld_count), 16'h2);
        chk("bp_ready",      16'(ld_ready), 16'h1);
        held = cpu_rdata;
        cpu_addr  = 12'h010;
        cpu_wdata = 16'hDEAD;
        cpu_rdwr  = 1'b1;
        cpu_en    = 1'b1;
        step();
        cpu_rdwr  = 1'b0;
        step();
        cpu_en    = 1'b0;
        chk("load_rdata_hold", cpu_rdata, held);
        chk("load_count_hold", 16'(ld_count), 16'h2);

        // Reset mid-load, then release without loading
        rstT = 1'b1;
        #2;
        rstT = 1'b0;
        step();
        chk("mid_cpu_rst",   16'(cpu_rst),  16'h1);
        chk("mid_count",     16'(ld_count), 16'h0);
        chk("mid_ready",     16'(ld_ready), 16'h0);
        chk("mid_unm_clr",   16'(unmapped), 16'h0);
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        chk("run_cpu_rst",   16'(cpu_rst),  16'h0);
        cpu_read("ret_a0", 12'h000);
        cpu_read("ret_a1", 12'h001);
        cpu_read("ret_a2", 12'h002);
        cpu_read("ret_a10", 12'h010);

        // Full load of all 256 words with no ld_last
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("full_cpu_rst",  16'(cpu_rst),  16'h1);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("full_ready_254", 16'(ld_ready), 16'h1);
                chk("full_count_255", 16'(ld_count), 16'h00FF);
            end
            load_word(16'hC000 ^ 16'(i), 1'b0);
            mdl[i] = 16'hC000 ^ 16'(i);
        end
        chk("full_ready",    16'(ld_ready), 16'h0);
        chk("full_cpu_rst0", 16'(cpu_rst),  16'h0);
        chk("full_count",    16'(ld_count), 16'h100);
        load_word(16'hEEEE, 1'b1);
        chk("extra_count",   16'(ld_count), 16'h100);
        cpu_read("full_a255", 12'h0FF);
        cpu_read("full_a0", 12'h000);
        cpu_read("full_a80", 12'h080);

        // run_start in RUN is ignored; ld_start reasserts cpu_rst next cycle
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        chk("run_ign_cpu_rst", 16'(cpu_rst), 16'h0);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("run_ld_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("run_ld_ready",   16'(ld_ready), 16'h1);

        rstT = 1'b1;
        step();
        chk("final_rdata",   cpu_rdata,     16'h0);
        chk("final_cpu_rst", 16'(cpu_rst),  16'h1);
        chk("sb_empty",      16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
